// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side sequencer for alu_32b.
//   Accepts one ALU instruction at a time on a valid/ready request channel.
//   Operands come from an internal register file (r0 reads as zero) or from an
//   immediate. They are presented to alu_32b and held for ALU_LAT cycles. The
//   result/flags are then sampled, written back to r[rd] and returned on a
//   valid/ready response channel.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_*       instruction request channel
//   load_en/load_addr/load_data     direct register-file write (any state)
//   dbg_addr/dbg_data               combinational register-file read port
//   alu_a/alu_b/alu_op              operands/opcode driven to alu_32b
//   alu_result/alu_flags            alu_32b outputs
//   rsp_valid/rsp_ready/rsp_*       response channel
//   flags_q                         flags of the last legal completed op
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8,
    parameter int AW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [5:0]    req_op,
    input  logic [AW-1:0] req_rd,
    input  logic [AW-1:0] req_ra,
    input  logic [AW-1:0] req_rb,
    input  logic          req_imm_en,
    input  logic [31:0]   req_imm,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [5:0]    alu_op,
    input  logic [31:0]   alu_result,
    input  logic [5:0]    alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_result,
    output logic [5:0]    rsp_flags,
    output logic          rsp_err,
    output logic [5:0]    flags_q
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [5:0] OP_ZEROS = 6'd15;

    state_t         state, nstate;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  rd_q;
    logic [31:0]    regs [NREGS];
    logic [31:0]    opa, opb;
    logic           accept, legal, last, wb;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == 6'd0) || (op >= 6'd2 && op <= 6'd6) || (op == 6'd9) ||
               (op >= 6'd13 && op <= 6'd29);
    endfunction

    // r0 is never written, but guard the read anyway so it is zero by design.
    function automatic logic [31:0] rf_rd(input logic [AW-1:0] a);
        return (a == '0) ? 32'd0 : regs[a];
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);
    assign legal     = op_legal(req_op);
    // cnt counts completed ISSUE cycles; the last one is where we sample.
    assign last      = (cnt == CW'(ALU_LAT - 1));
    assign wb        = (state == ISSUE) && last;
    assign opa       = rf_rd(req_ra);
    assign opb       = req_imm_en ? req_imm : rf_rd(req_rb);
    assign dbg_data  = rf_rd(dbg_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (accept) nstate = legal ? ISSUE : RESP;
            ISSUE:   if (last) nstate = RESP;
            RESP:    if (rsp_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Datapath / response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rd_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_ZEROS;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (accept) begin
                cnt <= '0;
                if (legal) begin
                    rd_q   <= req_rd;
                    alu_a  <= opa;
                    alu_b  <= opb;
                    alu_op <= req_op;
                end else begin
                    // Illegal op skips the ALU entirely and answers at once.
                    rsp_err    <= 1'b1;
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                end
            end
            if (state == ISSUE && !last) cnt <= cnt + 1'b1;
            if (wb) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                flags_q    <= alu_flags;
                rsp_err    <= 1'b0;
            end
        end
    end

    // Register file: writeback has priority over a same-cycle load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb && rd_q == AW'(i))
                    regs[i] <= alu_result;
                else if (load_en && load_addr == AW'(i))
                    regs[i] <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT=1 and ALU_LAT=3) driven by
// directed vectors, a transaction-level model checked every cycle, and a
// stand-in ALU that only produces a correct result once its inputs have been
// stable for ALU_LAT sampling cycles.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [5:0]  req_op [2];
    logic [2:0]  req_rd [2], req_ra [2], req_rb [2];
    logic        req_imm_en [2];
    logic [31:0] req_imm [2];
    logic        load_en [2];
    logic [2:0]  load_addr [2];
    logic [31:0] load_data [2];
    logic [2:0]  dbg_addr [2];
    logic [31:0] dbg_data [2];
    logic [31:0] alu_a [2], alu_b [2];
    logic [5:0]  alu_op [2];
    logic [31:0] alu_result [2];
    logic [5:0]  alu_flags [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_result [2];
    logic [5:0]  rsp_flags [2];
    logic        rsp_err [2];
    logic [5:0]  flags_q [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_issue_ctrl #(.ALU_LAT(g == 0 ? 1 : 3), .NREGS(8), .AW(3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_op(req_op[g]), .req_rd(req_rd[g]), .req_ra(req_ra[g]),
            .req_rb(req_rb[g]), .req_imm_en(req_imm_en[g]), .req_imm(req_imm[g]),
            .load_en(load_en[g]), .load_addr(load_addr[g]), .load_data(load_data[g]),
            .dbg_addr(dbg_addr[g]), .dbg_data(dbg_data[g]),
            .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
            .alu_result(alu_result[g]), .alu_flags(alu_flags[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_result(rsp_result[g]), .rsp_flags(rsp_flags[g]),
            .rsp_err(rsp_err[g]), .flags_q(flags_q[g])
        );
    end

    int checks = 0;
    int errs   = 0;

    // Stand-in ALU opcodes: 2=ADD, 4=SUB, 13=PASSB, 15=ZEROS.
    function automatic logic [31:0] f_res(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'd2:    return a + b;
            6'd4:    return a - b;
            6'd13:   return b;
            6'd15:   return 32'd0;
            default: return a ^ b ^ {26'd0, op};
        endcase
    endfunction
    function automatic logic [5:0] f_flg(input logic [5:0] op, input logic [31:0] r);
        return {r == 32'd0, r[31], op[3:0]};
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction
    function automatic logic is_legal(input logic [5:0] op);
        return op == 0 || (op >= 2 && op <= 6) || op == 9 || (op >= 13 && op <= 29);
    endfunction

    // Model state (transaction level: busy window + due cycle).
    logic        m_busy [2];
    int          m_cyc [2], m_due [2], m_wb_at [2], m_acc [2];
    logic        m_wb_pend [2];
    logic [31:0] m_pres [2];
    logic [5:0]  m_pflg [2];
    logic [2:0]  m_prd [2];
    logic [31:0] m_res [2], m_a [2], m_b [2];
    logic [5:0]  m_flg [2], m_fq [2], m_op [2];
    logic        m_err [2];
    logic [31:0] m_reg [2][8];
    logic [31:0] held_in [2][3];
    int          held [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_cyc[k] = 0; m_due[k] = 0; m_wb_at[k] = -1;
            m_wb_pend[k] = 1'b0; m_res[k] = '0; m_flg[k] = '0; m_err[k] = 1'b0;
            m_fq[k] = '0; m_a[k] = '0; m_b[k] = '0; m_op[k] = 6'd15;
            for (int r = 0; r < 8; r++) m_reg[k][r] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            automatic int cur = m_cyc[k];
            automatic logic was_busy = m_busy[k];
            automatic logic [31:0] a, b;
            if (m_busy[k] && cur >= m_due[k] && rsp_ready[k]) m_busy[k] = 1'b0;
            if (!was_busy && req_valid[k]) begin
                a = m_reg[k][req_ra[k]];
                b = req_imm_en[k] ? req_imm[k] : m_reg[k][req_rb[k]];
                m_busy[k] = 1'b1;
                m_acc[k]++;
                if (is_legal(req_op[k])) begin
                    m_a[k] = a; m_b[k] = b; m_op[k] = req_op[k];
                    m_pres[k] = f_res(req_op[k], a, b);
                    m_pflg[k] = f_flg(req_op[k], m_pres[k]);
                    m_prd[k] = req_rd[k];
                    m_due[k] = cur + 1 + lat_of(k);
                    m_wb_at[k] = cur + lat_of(k);
                    m_wb_pend[k] = 1'b1;
                end else begin
                    m_res[k] = '0; m_flg[k] = '0; m_err[k] = 1'b1;
                    m_due[k] = cur + 1;
                end
            end
            if (load_en[k] && load_addr[k] != 0) m_reg[k][load_addr[k]] = load_data[k];
            if (m_wb_pend[k] && cur == m_wb_at[k]) begin
                m_wb_pend[k] = 1'b0;
                m_res[k] = m_pres[k]; m_flg[k] = m_pflg[k]; m_err[k] = 1'b0;
                m_fq[k] = m_pflg[k];
                if (m_prd[k] != 0) m_reg[k][m_prd[k]] = m_pres[k];
            end
            m_cyc[k] = cur + 1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(!m_busy[k]));
            chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]),
                32'(m_busy[k] && m_cyc[k] >= m_due[k]));
            chk($sformatf("rsp_result[%0d]", k), rsp_result[k], m_res[k]);
            chk($sformatf("rsp_flags[%0d]", k), 32'(rsp_flags[k]), 32'(m_flg[k]));
            chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(m_err[k]));
            chk($sformatf("flags_q[%0d]", k), 32'(flags_q[k]), 32'(m_fq[k]));
            chk($sformatf("alu_a[%0d]", k), alu_a[k], m_a[k]);
            chk($sformatf("alu_b[%0d]", k), alu_b[k], m_b[k]);
            chk($sformatf("alu_op[%0d]", k), 32'(alu_op[k]), 32'(m_op[k]));
            chk($sformatf("dbg_data[%0d]", k), dbg_data[k], m_reg[k][dbg_addr[k]]);
        end
    endtask

    task automatic alu_step();
        for (int k = 0; k < 2; k++) begin
            if (alu_a[k] === held_in[k][0] && alu_b[k] === held_in[k][1] &&
                {26'd0, alu_op[k]} === held_in[k][2]) held[k]++;
            else held[k] = 1;
            held_in[k][0] = alu_a[k]; held_in[k][1] = alu_b[k];
            held_in[k][2] = {26'd0, alu_op[k]};
            if (held[k] >= lat_of(k)) begin
                alu_result[k] = f_res(alu_op[k], alu_a[k], alu_b[k]);
                alu_flags[k]  = f_flg(alu_op[k], alu_result[k]);
            end else begin
                alu_result[k] = 32'hDEADBEEF;
                alu_flags[k]  = 6'h2A;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [2:0] a, input logic [31:0] d);
        load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
        tick();
        load_en[k] = 1'b0;
    endtask

    // Returns in the cycle after the accepting edge.
    task automatic send(input int k, input logic [5:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic ie, input logic [31:0] imm);
        automatic int n = m_acc[k];
        automatic int t = 0;
        req_valid[k] = 1'b1; req_op[k] = op; req_rd[k] = rd; req_ra[k] = ra;
        req_rb[k] = rb; req_imm_en[k] = ie; req_imm[k] = imm;
        while (m_acc[k] == n && t < 20) begin tick(); t++; end
        req_valid[k] = 1'b0;
        if (m_acc[k] == n) chk("send_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_op[k] = 0; req_rd[k] = 0; req_ra[k] = 0; req_rb[k] = 0;
            req_imm_en[k] = 0; req_imm[k] = 0; load_en[k] = 0; load_addr[k] = 0;
            load_data[k] = 0; dbg_addr[k] = 0; rsp_ready[k] = 1; m_acc[k] = 0;
            alu_result[k] = 0; alu_flags[k] = 0; held[k] = 0;
            for (int j = 0; j < 3; j++) held_in[k][j] = '0;
        end
        model_reset();
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else        model_step();
            end
            forever begin
                @(negedge clk);
                alu_step();
                compare_all();
            end
            begin
                tick(); tick();
                rst_n = 1'b1;
                chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
                chk("rst_alu_op", 32'(alu_op[0]), 32'd15);
                chk("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
                chk("rst_flags_q", 32'(flags_q[1]), 32'd0);

                // ALU_LAT=1: ADD r3 = 4 + 0xFFFFFFFE
                load(0, 3'd1, 32'd4);
                load(0, 3'd2, 32'hFFFFFFFE);
                send(0, 6'd2, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
                chk("add_not_yet", 32'(rsp_valid[0]), 32'd0);
                tick();
                chk("add_valid", 32'(rsp_valid[0]), 32'd1);
                chk("add_result", rsp_result[0], 32'd2);
                chk("add_err", 32'(rsp_err[0]), 32'd0);
                tick();
                dbg_addr[0] = 3'd3;
                #1;
                chk("add_dbg_r3", dbg_data[0], 32'd2);
                chk("add_flags_q", 32'(flags_q[0]), 32'h02);

                // Illegal opcode 7
                send(0, 6'd7, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
                chk("ill_valid", 32'(rsp_valid[0]), 32'd1);
                chk("ill_err", 32'(rsp_err[0]), 32'd1);
                chk("ill_result", rsp_result[0], 32'd0);
                chk("ill_alu_op", 32'(alu_op[0]), 32'd2);
                chk("ill_flags_q", 32'(flags_q[0]), 32'h02);
                tick();
                chk("ill_dbg_r3", dbg_data[0], 32'd2);

                // PASSB immediate to r0 with response backpressure
                rsp_ready[0] = 1'b0;
                send(0, 6'd13, 3'd0, 3'd1, 3'd2, 1'b1, 32'h7FFFFFFF);
                chk("pb_not_yet", 32'(rsp_valid[0]), 32'd0);
                tick();
                chk("pb_valid", 32'(rsp_valid[0]), 32'd1);
                chk("pb_result", rsp_result[0], 32'h7FFFFFFF);
                req_valid[0] = 1'b1; req_op[0] = 6'd2; req_rd[0] = 3'd5;
                req_ra[0] = 3'd1; req_rb[0] = 3'd1; req_imm_en[0] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("stall_valid", 32'(rsp_valid[0]), 32'd1);
                    chk("stall_ready", 32'(req_ready[0]), 32'd0);
                    chk("stall_result", rsp_result[0], 32'h7FFFFFFF);
                    chk("stall_flags", 32'(rsp_flags[0]), 32'h0D);
                end
                rsp_ready[0] = 1'b1;
                tick();
                chk("post_hs_ready", 32'(req_ready[0]), 32'd1);
                chk("post_hs_valid", 32'(rsp_valid[0]), 32'd0);
                tick();
                req_valid[0] = 1'b0;
                chk("stalled_req_taken", 32'(req_ready[0]), 32'd0);
                dbg_addr[0] = 3'd0;
                #1;
                chk("r0_zero", dbg_data[0], 32'd0);
                tick();
                chk("add2_result", rsp_result[0], 32'd8);
                tick();
                dbg_addr[0] = 3'd5;
                #1;
                chk("add2_dbg_r5", dbg_data[0], 32'd8);

                // ALU_LAT=3: SUB r4 = 5 - 4, same-cycle load r4=9 loses
                load(1, 3'd1, 32'd5);
                load(1, 3'd2, 32'd4);
                send(1, 6'd4, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0);
                for (int i = 0; i < 3; i++) begin
                    chk("sub_alu_a", alu_a[1], 32'd5);
                    chk("sub_alu_b", alu_b[1], 32'd4);
                    chk("sub_alu_op", 32'(alu_op[1]), 32'd4);
                    chk("sub_not_yet", 32'(rsp_valid[1]), 32'd0);
                    if (i == 2) load(1, 3'd4, 32'd9);
                    else        tick();
                end
                chk("sub_valid", 32'(rsp_valid[1]), 32'd1);
                chk("sub_result", rsp_result[1], 32'd1);
                tick();
                dbg_addr[1] = 3'd4;
                #1;
                chk("wb_beats_load", dbg_data[1], 32'd1);

                // Reset during ISSUE aborts the instruction
                send(1, 6'd4, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0);
                rst_n = 1'b0;
                dbg_addr[1] = 3'd1;
                #1;
                chk("mid_rst_alu_op", 32'(alu_op[1]), 32'd15);
                chk("mid_rst_alu_a", alu_a[1], 32'd0);
                chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
                chk("mid_rst_r1", dbg_data[1], 32'd0);
                tick();
                rst_n = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    chk("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
                end
                load(1, 3'd1, 32'd7);
                load(1, 3'd2, 32'd2);
                send(1, 6'd4, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0);
                tick(); tick(); tick();
                chk("rst_next_valid", 32'(rsp_valid[1]), 32'd1);
                chk("rst_next_result", rsp_result[1], 32'd5);
                tick();
                dbg_addr[1] = 3'd6;
                #1;
                chk("rst_next_r6", dbg_data[1], 32'd5);
                tick(); tick();
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
